// File: rtl/prog_loader.sv
// Instruction-memory program loader: streams words into consecutive IM addresses and
// holds the CPU in reset until a full program has landed. Optional: LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [7:0]        Length,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InData,
    output logic              InReady,
    output logic              IM_WrEn,
    output logic [ADDR_W-1:0] IM_Addr,
    output logic [DATA_W-1:0] IM_WrData,
    output logic              CpuHold,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [7:0]        WordCount
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
    logic [DATA_W-1:0] csum;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
`endif

    state_t     state;
    logic [7:0] len_q;
    logic [7:0] wc_next;
    logic       len_ok;

    assign wc_next = WordCount + 8'd1;
    assign len_ok  = (Length != 8'd0) && (Length <= 8'd128);

`ifdef LOADER_CHECKSUM_EN
    assign Busy = (state == LOAD) || (state == CHECK);
`else
    assign Busy = (state == LOAD);
`endif
    assign InReady = Busy;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            len_q     <= '0;
            IM_WrEn   <= 1'b0;
            IM_Addr   <= '0;
            IM_WrData <= '0;
            CpuHold   <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
            WordCount <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            IM_WrEn <= 1'b0;
            if (Abort) begin
                state <= IDLE;
                Done  <= 1'b0;
                Error <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        // Hold release lags DONE by one edge so the last write lands first
                        if (state == DONE)
                            CpuHold <= 1'b0;
                        if (Start) begin
                            CpuHold <= 1'b1;
                            Done    <= 1'b0;
                            if (len_ok) begin
                                state     <= LOAD;
                                Error     <= 1'b0;
                                len_q     <= Length;
                                WordCount <= '0;
                                IM_Addr   <= '0;
`ifdef LOADER_CHECKSUM_EN
                                csum      <= '0;
`endif
                            end else begin
                                state <= ERROR;
                                Error <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (InValid) begin
                            IM_WrEn   <= 1'b1;
                            IM_WrData <= InData;
                            IM_Addr   <= WordCount[ADDR_W-1:0];
                            WordCount <= wc_next;
`ifdef LOADER_CHECKSUM_EN
                            csum      <= csum ^ InData;
                            if (wc_next == len_q)
                                state <= CHECK;
`else
                            if (wc_next == len_q) begin
                                state <= DONE;
                                Done  <= 1'b1;
                            end
`endif
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHECK: begin
                        // Trailing checksum word is compared, never written
                        if (InValid) begin
                            if (InData == csum) begin
                                state <= DONE;
                                Done  <= 1'b1;
                            end else begin
                                state <= ERROR;
                                Error <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory program loader for the 16-bit six-instruction processor. Accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at 0. It holds the processor in reset until a complete program has been written. It is the write side of the instruction memory that the processor's control unit reads through its 7-bit program counter.

## Interface
- ADDR_W, 7, instruction-memory address width; matches the program counter width
- DATA_W, 16, instruction word width
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin a load session; sampled in IDLE, DONE and ERROR
- Abort  in  1  synchronous abort; returns to IDLE from any state
- Length  in  8  number of program words; sampled with Start
- InValid  in  1  InData holds a word
- InData  in  DATA_W  incoming instruction word
- InReady  out  1  loader accepts a word this cycle
- IM_WrEn  out  1  instruction-memory write strobe
- IM_Addr  out  ADDR_W  instruction-memory write address
- IM_WrData  out  DATA_W  instruction-memory write data
- CpuHold  out  1  high holds the processor in reset
- Busy  out  1  load session in progress (LOAD or CHECK)
- Done  out  1  last load completed successfully
- Error  out  1  last load failed
- WordCount  out  8  words written in the current or last session

## Operation
- States: IDLE, LOAD, CHECK (macro only), DONE, ERROR.
- Reset values:
  - state=IDLE
  - CpuHold=1
  - all other outputs 0
- IDLE/DONE/ERROR with Start=1:
  - Length in 1..128 → LOAD; clear WordCount, IM_Addr and checksum; CpuHold=1; Done=Error=0.
  - Length of 0 or >128 → ERROR.
- LOAD:
  - InReady=1.
  - A transfer occurs on a rising edge with InValid=1 and InReady=1.
  - Each transfer registers IM_WrData=InData and IM_Addr=WordCount, sets IM_WrEn=1 for exactly one cycle, increments WordCount and XOR-accumulates InData into the checksum.
  - After the transfer that makes WordCount equal Length → CHECK when the macro is defined, otherwise → DONE.
- CHECK:
  - InReady=1.
  - The next transfer is the checksum word; it is not written to memory.
  - Equal to the accumulated checksum → DONE; otherwise → ERROR.
- DONE: Done=1. CpuHold clears on the edge after DONE is entered, so the final memory write has landed first.
- ERROR: Error=1, CpuHold stays 1. The processor never runs a partial or corrupt program.
- Abort:
  - Abort=1 at any edge → IDLE, IM_WrEn=0, Done=Error=0.
  - CpuHold is unchanged by Abort. It is set only by Start and cleared only via DONE.
- Start while Busy is ignored. Start and Abort in the same cycle: Abort wins.
- InValid outside LOAD/CHECK is ignored; no word is consumed.
- IM_Addr wraps never: Length ≤ 128 bounds it to 0..127.

## Timing
- InReady is combinational from state. Start at edge S → InReady=1 from S.
- Write latency: a word transferred at edge E is driven on IM_* during cycle E..E+1 and written at edge E+1.
- Full rate: one word per cycle when InValid is held high. Throughput equals Length cycles plus 1 when the checksum word is enabled.
- Last data (or checksum) transfer at edge E:
  - Done=1 from E.
  - CpuHold=0 from E+1.
- Checksum mismatch at edge E → Error=1 from E.
- Reset asserted mid-session: everything returns to reset values immediately. The write in flight is dropped (IM_WrEn=0 asynchronously).

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECK state exists; one trailing checksum word is required.
  - The checksum is the 16-bit XOR of all data words.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no checksum logic.
  - DONE follows the last data word directly.
  - ERROR is reachable only through an illegal Length.

## Test plan
- Reset, Start with Length=3, words 16'h1234, 16'hABCD, 16'h0F0F on consecutive cycles (no macro) → writes at addresses 0,1,2. Done=1 on the third transfer edge; CpuHold=0 one cycle later; WordCount=3.
- Macro on, Length=2, words 16'h00FF, 16'hFF00, checksum 16'hFFFF → DONE. Repeat with checksum 16'h0000 → Error=1, CpuHold=1, exactly 2 memory writes.
- Start with Length=0 and with Length=129 → ERROR next edge; no IM_WrEn pulses.
- Length=128 with InValid toggled 1/0 each cycle → 128 writes, addresses 0..127 in order. No write occurs on any InValid=0 cycle.
- Abort after 5 of 10 words → IDLE, CpuHold=1, 5 writes only. A new Start with Length=1 then completes normally.
- Reset pulled low the cycle after a transfer → IM_WrEn=0 immediately, state IDLE, CpuHold=1.
